// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine in front of a word-addressed data memory
module load_store_unit #(
    parameter int MEM_WORDS = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);
    typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, ERR} state_t;

    state_t            state_q, state_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [31:0]       mem_wd_q, mem_wd_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;

    logic              accept;
    logic              bad;
    logic [ADDR_W-1:0] idx;
    logic [4:0]        sh;
    logic [7:0]        ld_b;
    logic [15:0]       ld_h;
    logic [31:0]       msk;

    assign req_ready  = state_q == IDLE;
    assign accept     = req_valid && req_ready;
    assign idx        = {2'b00, req_addr[ADDR_W-1:2]};
    assign bad        = (req_size == 2'b11)
                      | (req_size == 2'b01 && req_addr[0])
                      | (req_size == 2'b10 && |req_addr[1:0])
                      | (idx >= ADDR_W'(MEM_WORDS));
    assign sh         = {lane_q, 3'b000};
    assign ld_b       = 8'(mem_rd >> sh);
    assign ld_h       = lane_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    assign msk        = (size_q == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    assign mem_we     = state_q == WRITE;
    assign mem_a      = mem_a_q;
    assign mem_wd     = mem_wd_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

    // Next-state and datapath: latch on accept, extract/extend loads, merge partial stores
    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        uns_d        = uns_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        mem_a_d      = mem_a_q;
        mem_wd_d     = mem_wd_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
        case (state_q)
            IDLE: if (accept) begin
                size_d   = req_size;
                uns_d    = req_unsigned;
                lane_d   = req_addr[1:0];
                wdata_d  = req_wdata;
                mem_a_d  = idx;
                mem_wd_d = req_wdata;
                state_d  = bad ? ERR : !req_we ? LOAD : req_size == 2'b10 ? WRITE : MERGE;
            end
            LOAD: begin
                resp_rdata_d = size_q == 2'b10 ? mem_rd
                             : size_q == 2'b01 ? {{16{~uns_q & ld_h[15]}}, ld_h}
                             : {{24{~uns_q & ld_b[7]}}, ld_b};
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            MERGE: begin
                mem_wd_d = (mem_rd & ~msk) | ((wdata_q << sh) & msk);
                state_d  = WRITE;
            end
            WRITE: begin
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            ERR: begin
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; async reset kills any in-flight write immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            lane_q       <= 2'b00;
            wdata_q      <= 32'h0;
            mem_a_q      <= '0;
            mem_wd_q     <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            mem_a_q      <= mem_a_d;
            mem_wd_q     <= mem_wd_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scoreboard bench for load_store_unit with a behavioural data memory
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:1023];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_a = 10'd0;
    logic [31:0] pre_d = 32'h0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          we_cnt = 0;
    logic [31:0] last_wa = 32'h0;
    logic [31:0] last_wd = 32'h0;

    always #5 clk = ~clk;

    // Behavioural data memory: combinational read, write at the rising edge, plus a preload port
    always @(posedge clk) begin
        if (pre_we) mem[pre_a] <= pre_d;
        else if (mem_we && mem_a < 32'd1024) mem[mem_a[9:0]] <= mem_wd;
    end

    assign mem_rd = (mem_a < 32'd1024) ? mem[mem_a[9:0]] : 32'h0;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: advance to the falling edge, log writes, score any response
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (mem_we) begin
            we_cnt++;
            last_wa = mem_a;
            last_wd = mem_wd;
        end
        if (resp_valid) begin
            if (sb.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk("resp_err", 32'(resp_err), 32'(e.err));
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_latency", 32'(cyc), 32'(e.due));
            end
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic err, input logic [31:0] rd, input int lat,
                         input logic hold, input logic b2b);
        exp_t e;
        int   n = 0;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_valid    = 1'b1;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        chk("accept_wait", 32'(n < 20), 32'd1);
        if (b2b) chk("b2b_accept_in_resp_cycle", 32'(resp_valid), 32'd1);
        e.err   = err;
        e.rdata = rd;
        e.due   = cyc + lat;
        sb.push_back(e);
        tick();
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
        tick();
    endtask

    initial begin
        pre_we = 1'b1;
        pre_a  = 10'd30;
        pre_d  = 32'h0000_0020;
        tick();
        pre_a  = 10'd31;
        pre_d  = 32'h0;
        tick();
        pre_we = 1'b0;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wd", mem_wd, 32'h0);
        rst_n = 1'b1;
        tick();

        issue(1'b0, 2'b10, 1'b0, 32'h78, 32'h0, 1'b0, 32'h0000_0020, 2, 1'b0, 1'b0);
        chk("load_busy_not_ready", 32'(req_ready), 32'd0);
        drain();
        chk("load_no_write", 32'(we_cnt), 32'd0);

        issue(1'b1, 2'b00, 1'b0, 32'h79, 32'h0000_00AB, 1'b0, 32'h0, 3, 1'b0, 1'b0);
        drain();
        chk("sb_we_count", 32'(we_cnt), 32'd1);
        chk("sb_mem_a", last_wa, 32'd30);
        chk("sb_mem_wd", last_wd, 32'h0000_AB20);
        chk("sb_mem30", mem[30], 32'h0000_AB20);

        issue(1'b0, 2'b00, 1'b0, 32'h79, 32'h0, 1'b0, 32'hFFFF_FFAB, 2, 1'b0, 1'b0);
        drain();
        issue(1'b0, 2'b00, 1'b1, 32'h79, 32'h0, 1'b0, 32'h0000_00AB, 2, 1'b0, 1'b0);
        drain();
        issue(1'b0, 2'b01, 1'b1, 32'h78, 32'h0, 1'b0, 32'h0000_AB20, 2, 1'b0, 1'b0);
        drain();

        issue(1'b1, 2'b01, 1'b0, 32'h7A, 32'h0000_1234, 1'b0, 32'h0, 3, 1'b1, 1'b0);
        issue(1'b1, 2'b10, 1'b0, 32'h7C, 32'hDEAD_BEEF, 1'b0, 32'h0, 2, 1'b1, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'h78, 32'h0, 1'b0, 32'h1234_AB20, 2, 1'b1, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'h7C, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 1'b0, 1'b1);
        drain();
        chk("b2b_we_count", 32'(we_cnt), 32'd3);
        chk("b2b_mem31", mem[31], 32'hDEAD_BEEF);

        issue(1'b0, 2'b01, 1'b0, 32'h7B, 32'h0, 1'b1, 32'h0, 2, 1'b0, 1'b0);
        drain();
        issue(1'b1, 2'b10, 1'b0, 32'h7A, 32'hFFFF_FFFF, 1'b1, 32'h0, 2, 1'b0, 1'b0);
        drain();
        issue(1'b1, 2'b11, 1'b0, 32'h78, 32'hFFFF_FFFF, 1'b1, 32'h0, 2, 1'b0, 1'b0);
        drain();
        issue(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 1'b1, 32'h0, 2, 1'b0, 1'b0);
        drain();
        chk("err_we_count", 32'(we_cnt), 32'd3);
        chk("err_mem30", mem[30], 32'h1234_AB20);
        chk("err_mem31", mem[31], 32'hDEAD_BEEF);

        issue(1'b1, 2'b00, 1'b0, 32'h79, 32'h0000_00CD, 1'b0, 32'h0, 3, 1'b0, 1'b0);
        chk("merge_not_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_we", 32'(mem_we), 32'd0);
        sb.delete();
        tick();
        tick();
        chk("rst_mid_mem30", mem[30], 32'h1234_AB20);
        chk("rst_mid_we_count", 32'(we_cnt), 32'd3);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("post_rst_resp_err", 32'(resp_err), 32'd0);

        issue(1'b0, 2'b01, 1'b0, 32'h7A, 32'h0, 1'b0, 32'h0000_1234, 2, 1'b0, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
